alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit registered ALU for the datapath execute stage.
- Takes a 4-bit operation code and two operands from the operand muxes (top and bottom).
- Produces a result, a secondary result (division remainder, or the multiply high word) and an overflow flag.
- All outputs are registered, with one clock of latency.

Parameters:
- WIDTH, 16, operand/result width. All values below assume 16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- CTRL  input  4  operation select
- MUX_intop  input  16  operand A, two's complement
- MUX_inbottom  input  16  operand B, two's complement (shift/rotate amount for codes 6-9)
- ALU_Result  output  16  primary result
- Remainder  output  16  division remainder or multiply high word, else 0
- Overflow_flag  output  1  arithmetic overflow / divide fault

Behaviour:
- Reset: while rst_n = 0, ALU_Result = 0, Remainder = 0 and Overflow_flag = 0, asynchronously. Reset mid-operation discards that operation.
- Timing: the next-state values are computed combinationally from the current inputs and loaded on every rising clk edge. Outputs reflect the inputs sampled at the previous edge (latency 1, throughput 1/cycle). There is no handshake.
- Remainder = 0 and Overflow_flag = 0 unless stated otherwise below.
- Operation codes (A = MUX_intop, B = MUX_inbottom):
  - 0 ADD: Result = A+B mod 2^16. Overflow = signed overflow (A and B have the same sign and the result sign differs).
  - 1 SUB: Result = A-B mod 2^16. Overflow = signed overflow (A and B have different signs and the result sign differs from A).
  - 2 AND: bitwise A & B.
  - 3 OR: bitwise A | B.
  - 4 MUL: signed 16x16 -> 32-bit product. Result = product[15:0], Remainder = product[31:16]. Overflow = 1 when the product is not representable in signed 16 bits.
  - 5 DIV: signed division truncating toward zero. Result = quotient; Remainder takes the sign of A.
    - B = 0: Result = 0xFFFF, Remainder = A, Overflow = 1.
    - A = 0x8000 and B = 0xFFFF: Result = 0x8000, Remainder = 0, Overflow = 1.
  - 6 SHL: logical left shift of A by B, with B taken as unsigned 16-bit. B >= 16 gives 0.
  - 7 SAR: arithmetic right shift of A by B (unsigned), sign-filling. B >= 16 gives all copies of A[15].
  - 8 ROL: rotate A left by B mod 16.
  - 9 ROR: rotate A right by B mod 16.
  - 10 HALT: all three output registers hold their previous values; nothing updates.
  - 11-15: reserved. Result = 0, Remainder = 0, Overflow = 0.
- Division may be a single-cycle combinational divider; no multi-cycle stall is permitted.
- Back-to-back code changes take effect on each edge independently; no state is carried between operations except the HALT hold.

Test Plan:
- ADD/SUB/AND/OR with A=1000, B=50:
  - ADD -> 1050, OV 0
  - SUB -> 950, OV 0
  - AND -> 32
  - OR -> 1018
  - Also ADD 0x7FFF+1 -> 0x8000, OV 1.
- MUL:
  - A=32000, B=5 -> Result 28928 (0x7100), Remainder 2, OV 1.
  - A=-3, B=7 -> Result 0xFFEB, Remainder 0xFFFF, OV 0.
- DIV:
  - 25/6 -> 4 rem 1, OV 0.
  - -25/6 -> 0xFFFC rem 0xFFFF.
  - 25/0 -> 0xFFFF rem 25, OV 1.
  - 0x8000/0xFFFF -> 0x8000, OV 1.
- Shifts/rotates:
  - SHL 18 by 1 -> 36.
  - SAR 18 by 1 -> 9.
  - SAR 0x8000 by 20 -> 0xFFFF.
  - ROL 1000 by 50 -> 4000.
  - ROR 1000 by 50 -> 250.
- HALT/reserved:
  - ADD 1000+50, then CTRL=10 with new operands -> outputs stay 1050/0/0.
  - Then CTRL=12 -> all outputs 0.
- Reset:
  - Assert rst_n=0 between clock edges after a MUL -> all outputs 0 immediately.
  - Release, then apply ADD 1+1 -> 2 appears one edge later.

Source files
------------

// File: rtl/alu.sv
// Registered 16-bit execute-stage ALU: add/sub/logic/mul/div/shift/rotate.
// Next-state values are formed combinationally (p0) and loaded each edge (p1).
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       CTRL,
  input  logic [WIDTH-1:0] MUX_intop,
  input  logic [WIDTH-1:0] MUX_inbottom,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Overflow_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_MUL = 4'd4, OP_DIV = 4'd5, OP_SHL = 4'd6, OP_SAR = 4'd7,
    OP_ROL = 4'd8, OP_ROR = 4'd9, OP_HLT = 4'd10
  } op_e;

  // Product packed as {ovf, high word, low word}; ovf when high word is not a sign extension.
  function automatic logic [2*WIDTH:0] mul_op(input logic signed [WIDTH-1:0] a_s,
                                               input logic signed [WIDTH-1:0] b_s);
    logic signed [2*WIDTH-1:0] a_x, b_x, prod;
    logic ovf;
    a_x  = $signed({{WIDTH{a_s[WIDTH-1]}}, a_s});
    b_x  = $signed({{WIDTH{b_s[WIDTH-1]}}, b_s});
    prod = a_x * b_x;
    ovf  = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    return {ovf, prod};
  endfunction

  // Quotient packed as {ovf, remainder, quotient}; faults give fixed results.
  function automatic logic [2*WIDTH:0] div_op(input logic signed [WIDTH-1:0] a_s,
                                               input logic signed [WIDTH-1:0] b_s);
    logic signed [WIDTH-1:0] q, r;
    logic ovf;
    if (b_s == '0) begin
      q = '1; r = a_s; ovf = 1'b1;
    end else if (a_s == MIN_VAL && b_s == '1) begin
      q = MIN_VAL; r = '0; ovf = 1'b1;
    end else begin
      q = a_s / b_s; r = a_s % b_s; ovf = 1'b0;
    end
    return {ovf, r, q};
  endfunction

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        sum_p0, diff_p0, res_p0, rem_p0;
  logic [WIDTH-1:0]        res_p1, rem_p1;
  logic [2*WIDTH:0]        mul_p0, div_p0;
  logic [2*WIDTH-1:0]      rol_p0, ror_p0;
  logic [SHW-1:0]          sh_p0;
  logic                    big_sh_p0, ovf_p0, hold_p0, ovf_p1;

  assign a_s       = $signed(MUX_intop);
  assign b_s       = $signed(MUX_inbottom);
  assign sum_p0    = MUX_intop + MUX_inbottom;
  assign diff_p0   = MUX_intop - MUX_inbottom;
  assign mul_p0    = mul_op(a_s, b_s);
  assign div_p0    = div_op(a_s, b_s);
  assign sh_p0     = MUX_inbottom[SHW-1:0];
  assign big_sh_p0 = |MUX_inbottom[WIDTH-1:SHW];
  assign rol_p0    = {MUX_intop, MUX_intop} << sh_p0;
  assign ror_p0    = {MUX_intop, MUX_intop} >> sh_p0;

  // Stage p0: next-state selection
  always_comb begin
    res_p0  = '0;
    rem_p0  = '0;
    ovf_p0  = 1'b0;
    hold_p0 = 1'b0;
    case (CTRL)
      OP_ADD: begin
        res_p0 = sum_p0;
        ovf_p0 = add_ovf(MUX_intop[WIDTH-1], MUX_inbottom[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_p0 = diff_p0;
        ovf_p0 = add_ovf(MUX_intop[WIDTH-1], ~MUX_inbottom[WIDTH-1], diff_p0[WIDTH-1]);
      end
      OP_AND: res_p0 = MUX_intop & MUX_inbottom;
      OP_OR:  res_p0 = MUX_intop | MUX_inbottom;
      OP_MUL: begin
        res_p0 = mul_p0[WIDTH-1:0];
        rem_p0 = mul_p0[2*WIDTH-1:WIDTH];
        ovf_p0 = mul_p0[2*WIDTH];
      end
      OP_DIV: begin
        res_p0 = div_p0[WIDTH-1:0];
        rem_p0 = div_p0[2*WIDTH-1:WIDTH];
        ovf_p0 = div_p0[2*WIDTH];
      end
      OP_SHL: res_p0 = big_sh_p0 ? '0 : (MUX_intop << sh_p0);
      OP_SAR: res_p0 = big_sh_p0 ? {WIDTH{MUX_intop[WIDTH-1]}} : $unsigned(a_s >>> sh_p0);
      OP_ROL: res_p0 = rol_p0[2*WIDTH-1:WIDTH];
      OP_ROR: res_p0 = ror_p0[WIDTH-1:0];
      OP_HLT: hold_p0 = 1'b1;
      default: ;
    endcase
  end

  // Stage p1: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      rem_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else if (!hold_p0) begin
      res_p1 <= res_p0;
      rem_p1 <= rem_p0;
      ovf_p1 <= ovf_p0;
    end
  end

  assign ALU_Result    = res_p1;
  assign Remainder     = rem_p1;
  assign Overflow_flag = ovf_p1;

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: directed vectors plus randomised vectors
// checked against an integer reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [15:0] a_in = 16'd0;
  logic [15:0] b_in = 16'd0;
  logic [15:0] alu_res, alu_rem;
  logic        alu_ovf;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] rem;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp = '0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  alu #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .CTRL         (ctrl),
    .MUX_intop    (a_in),
    .MUX_inbottom (b_in),
    .ALU_Result   (alu_res),
    .Remainder    (alu_rem),
    .Overflow_flag(alu_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int sa, sb, ua, ub, r, q, n;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    ua = {16'd0, a};
    ub = {16'd0, b};
    case (c)
      4'd0: begin r = sa + sb; e.res = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; e.res = r[15:0]; e.ovf = (r > 32767) || (r < -32768); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: begin
        r = sa * sb; e.res = r[15:0]; e.rem = r[31:16];
        e.ovf = (r > 32767) || (r < -32768);
      end
      4'd5: begin
        if (sb == 0) begin
          e.res = 16'hFFFF; e.rem = a; e.ovf = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
          e.res = 16'h8000; e.rem = 16'h0000; e.ovf = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb; e.res = q[15:0]; e.rem = r[15:0];
        end
      end
      4'd6: begin r = (ub >= 16) ? 0 : (ua << ub); e.res = r[15:0]; end
      4'd7: begin r = sa >>> ((ub >= 16) ? 15 : ub); e.res = r[15:0]; end
      4'd8: begin n = ub % 16; r = (ua << n) | (ua >> (16 - n)); e.res = r[15:0]; end
      4'd9: begin n = ub % 16; r = (ua >> n) | (ua << (16 - n)); e.res = r[15:0]; end
      4'd10: e = last_exp;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic apply(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [15:0] erm, input logic eo,
                       input string tag);
    exp_t e;
    @(negedge clk);
    ctrl = c; a_in = a; b_in = b;
    e.res = er; e.rem = erm; e.ovf = eo;
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_res"}, {16'd0, alu_res}, {16'd0, e.res});
      check_val({tag, "_rem"}, {16'd0, alu_rem}, {16'd0, e.rem});
      check_val({tag, "_ovf"}, {31'd0, alu_ovf}, {31'd0, e.ovf});
    end
  endtask

  task automatic apply_model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                             input string tag);
    exp_t m;
    m = model(c, a, b);
    apply(c, a, b, m.res, m.rem, m.ovf, tag);
  endtask

  initial begin
    #12;
    check_val("rst_res", {16'd0, alu_res}, 32'd0);
    check_val("rst_rem", {16'd0, alu_rem}, 32'd0);
    check_val("rst_ovf", {31'd0, alu_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(4'd0, 16'd1000, 16'd50, 16'd1050, 16'd0, 1'b0, "add");
    apply(4'd1, 16'd1000, 16'd50, 16'd950,  16'd0, 1'b0, "sub");
    apply(4'd2, 16'd1000, 16'd50, 16'd32,   16'd0, 1'b0, "and");
    apply(4'd3, 16'd1000, 16'd50, 16'd1018, 16'd0, 1'b0, "or");
    apply(4'd0, 16'h7FFF, 16'd1,  16'h8000, 16'd0, 1'b1, "add_ovf");
    apply(4'd1, 16'h8000, 16'd1,  16'h7FFF, 16'd0, 1'b1, "sub_ovf");
    apply(4'd4, 16'd32000, 16'd5, 16'd28928, 16'd2, 1'b1, "mul_big");
    apply(4'd4, 16'hFFFD, 16'd7,  16'hFFEB, 16'hFFFF, 1'b0, "mul_neg");
    apply(4'd5, 16'd25, 16'd6,    16'd4,    16'd1, 1'b0, "div");
    apply(4'd5, 16'hFFE7, 16'd6,  16'hFFFC, 16'hFFFF, 1'b0, "div_neg");
    apply(4'd5, 16'd25, 16'd0,    16'hFFFF, 16'd25, 1'b1, "div_zero");
    apply(4'd5, 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b1, "div_min");
    apply(4'd6, 16'd18, 16'd1,    16'd36,   16'd0, 1'b0, "shl");
    apply(4'd6, 16'hFFFF, 16'd16, 16'd0,    16'd0, 1'b0, "shl_big");
    apply(4'd7, 16'd18, 16'd1,    16'd9,    16'd0, 1'b0, "sar");
    apply(4'd7, 16'h8000, 16'd20, 16'hFFFF, 16'd0, 1'b0, "sar_big");
    apply(4'd8, 16'd1000, 16'd50, 16'd4000, 16'd0, 1'b0, "rol");
    apply(4'd9, 16'd1000, 16'd50, 16'd250,  16'd0, 1'b0, "ror");

    apply(4'd0, 16'd1000, 16'd50, 16'd1050, 16'd0, 1'b0, "pre_halt");
    apply(4'd10, 16'd7, 16'd9,    16'd1050, 16'd0, 1'b0, "halt");
    apply(4'd12, 16'd7, 16'd9,    16'd0,    16'd0, 1'b0, "resv");

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  c;
      logic [15:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      apply_model(c, a, b, "rnd");
    end

    apply(4'd4, 16'd32000, 16'd5, 16'd28928, 16'd2, 1'b1, "mul_pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_res", {16'd0, alu_res}, 32'd0);
    check_val("arst_rem", {16'd0, alu_rem}, 32'd0);
    check_val("arst_ovf", {31'd0, alu_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd0, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
